// File: rtl/rpn_pkg.sv
// Shared encodings for the RPN engine: stack commands, token fields,
// FSM states and error codes.
package rpn_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_CLR  = 2'b01,
    CMD_PUSH = 2'b10,
    CMD_POP  = 2'b11
  } stk_cmd_e;

  localparam logic [1:0] KIND_OPND  = 2'b00;
  localparam logic [1:0] KIND_OPER  = 2'b01;
  localparam logic [1:0] KIND_CLEAR = 2'b10;
  localparam logic [1:0] KIND_ILL   = 2'b11;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;
  localparam logic [1:0] ERR_ILL  = 2'b11;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_IDLE   = 4'd1,
    ST_PUSH   = 4'd2,
    ST_CLEAR  = 4'd3,
    ST_POP_B  = 4'd4,
    ST_WT_B   = 4'd5,
    ST_CAP_B  = 4'd6,
    ST_POP_A  = 4'd7,
    ST_WT_A   = 4'd8,
    ST_CAP_A  = 4'd9,
    ST_PUSH_R = 4'd10
  } state_e;

  // Moore mapping from FSM state to the command presented to the stack.
  function automatic stk_cmd_e state_cmd(input state_e s);
    case (s)
      ST_INIT, ST_CLEAR:  return CMD_CLR;
      ST_PUSH, ST_PUSH_R: return CMD_PUSH;
      ST_POP_B, ST_POP_A: return CMD_POP;
      default:            return CMD_NOP;
    endcase
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/rpn_if.sv
// Token channel from the expression producer into the RPN engine.
interface rpn_if;
  // A token transfers on a rising edge where tok_valid && tok_ready are both
  // high; the producer holds kind/op/val stable while tok_valid waits on ready.
  logic       tok_valid;
  logic       tok_ready;
  logic [1:0] tok_kind;
  logic [2:0] tok_op;
  logic [7:0] tok_val;

  modport master (output tok_valid, output tok_kind, output tok_op,
                  output tok_val, input tok_ready);
  modport slave  (input tok_valid, input tok_kind, input tok_op,
                  input tok_val, output tok_ready);
endinterface

// File: rtl/rpn_alu.sv
// Combinational 8-bit operator unit; a is the deeper stack entry.
module rpn_alu
  import rpn_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] y_o
);

  always_comb begin
    y_o = 8'h00;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_MUL:  y_o = a_i * b_i;
      default: y_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/rpn_engine.sv
// Postfix expression engine driving an 8-deep hardware stack; tracks depth
// itself so overflowing pushes and underflowing pops never reach the stack.
module rpn_engine
  import rpn_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  rpn_if.slave       tok,
  output logic [1:0] stk_cmd,
  output logic [7:0] stk_din,
  input  logic [7:0] stk_dout,
  input  logic       stk_full,
  input  logic       stk_empty,
  input  logic       stk_error,
  output logic [3:0] depth,
  output logic [7:0] result,
  output logic       res_valid,
  output logic       err,
  output logic [1:0] err_code,
  output logic       stk_fault,
  output state_e     dbg_state
);

  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  state_e     state_q, state_d;
  stk_cmd_e   stk_cmd_q, stk_cmd_d;
  logic [7:0] stk_din_q, stk_din_d;
  logic [3:0] depth_q, depth_d;
  logic [7:0] result_q, result_d;
  logic       res_valid_q, res_valid_d;
  logic       err_q, err_d;
  logic [1:0] err_code_q, err_code_d;
  logic       fault_q, fault_d;
  logic [2:0] op_q, op_d;
  logic [7:0] b_q, b_d;
  logic [7:0] alu_y;
  logic       accept;

  // Depth is the authoritative occupancy; the stack's full/empty flags are
  // only meaningful to other observers of the stack.
  logic unused_flags;
  assign unused_flags = stk_full ^ stk_empty;

  assign accept        = tok.tok_valid && tok.tok_ready;
  assign tok.tok_ready = (state_q == ST_IDLE);

  // Operand a is whatever the second pop returns, consumed in CAP_A.
  rpn_alu u_alu (
    .op_i (op_q),
    .a_i  (stk_dout),
    .b_i  (b_q),
    .y_o  (alu_y)
  );

  always_comb begin
    state_d     = state_q;
    stk_din_d   = stk_din_q;
    depth_d     = depth_q;
    result_d    = result_q;
    res_valid_d = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    fault_d     = fault_q;
    op_d        = op_q;
    b_d         = b_q;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (stk_error) fault_d = 1'b1;
        if (accept) begin
          case (tok.tok_kind)
            KIND_OPND: begin
              if (depth_q < DEPTH_L) begin
                state_d   = ST_PUSH;
                stk_din_d = tok.tok_val;
              end else begin
                err_d      = 1'b1;
                err_code_d = ERR_OVF;
              end
            end
            KIND_OPER: begin
              // An illegal opcode is reported even when the stack is short.
              if (!op_legal(tok.tok_op)) begin
                err_d      = 1'b1;
                err_code_d = ERR_ILL;
              end else if (depth_q < 4'd2) begin
                err_d      = 1'b1;
                err_code_d = ERR_UNF;
              end else begin
                state_d = ST_POP_B;
                op_d    = tok.tok_op;
              end
            end
            KIND_CLEAR: begin
              state_d = ST_CLEAR;
              depth_d = 4'd0;
              fault_d = 1'b0;
            end
            default: begin
              err_d      = 1'b1;
              err_code_d = ERR_ILL;
            end
          endcase
        end
      end
      ST_PUSH: begin
        depth_d = depth_q + 4'd1;
        state_d = ST_IDLE;
      end
      ST_CLEAR: state_d = ST_IDLE;
      ST_POP_B: state_d = ST_WT_B;
      ST_WT_B:  state_d = ST_CAP_B;
      ST_CAP_B: begin
        b_d     = stk_dout;
        state_d = ST_POP_A;
      end
      ST_POP_A: state_d = ST_WT_A;
      ST_WT_A:  state_d = ST_CAP_A;
      ST_CAP_A: begin
        stk_din_d = alu_y;
        state_d   = ST_PUSH_R;
      end
      ST_PUSH_R: begin
        result_d    = stk_din_q;
        res_valid_d = 1'b1;
        depth_d     = depth_q - 4'd1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
    stk_cmd_d = state_cmd(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      stk_cmd_q   <= CMD_CLR;
      stk_din_q   <= 8'h00;
      depth_q     <= 4'd0;
      result_q    <= 8'h00;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      fault_q     <= 1'b0;
      op_q        <= OP_ADD;
      b_q         <= 8'h00;
    end else begin
      state_q     <= state_d;
      stk_cmd_q   <= stk_cmd_d;
      stk_din_q   <= stk_din_d;
      depth_q     <= depth_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      fault_q     <= fault_d;
      op_q        <= op_d;
      b_q         <= b_d;
    end
  end

  assign stk_cmd   = stk_cmd_q;
  assign stk_din   = stk_din_q;
  assign depth     = depth_q;
  assign result    = result_q;
  assign res_valid = res_valid_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign stk_fault = fault_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rpn_engine.sv
// Directed bench for rpn_engine with a behavioural 8x8 stack on its stack port.
module tb_rpn_engine;
  import rpn_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rpn_if tok_if ();

  logic [1:0] stk_cmd;
  logic [7:0] stk_din;
  logic [7:0] stk_dout  = 8'h00;
  logic       stk_full  = 1'b0;
  logic       stk_empty = 1'b1;
  logic       stk_error;
  logic [3:0] depth;
  logic [7:0] result;
  logic       res_valid, err, stk_fault;
  logic [1:0] err_code;
  state_e     dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  rpn_engine #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .tok       (tok_if),
    .stk_cmd   (stk_cmd),
    .stk_din   (stk_din),
    .stk_dout  (stk_dout),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .stk_error (stk_error),
    .depth     (depth),
    .result    (result),
    .res_valid (res_valid),
    .err       (err),
    .err_code  (err_code),
    .stk_fault (stk_fault),
    .dbg_state (dbg_state)
  );

  // Stack model: command taken at the rising edge, flags and pop data at the
  // following falling edge.
  logic [7:0] mem [8];
  int         sp = 0;
  logic [7:0] pop_val = 8'h00;
  logic       err_pend = 1'b0;
  logic       model_err = 1'b0;
  logic       inj_err = 1'b0;
  assign stk_error = model_err | inj_err;

  logic [9:0] cmd_q[$];
  logic [9:0] exp_q[$];
  int rv_cnt = 0, err_cnt = 0, both_cnt = 0;

  always @(posedge clk) begin
    err_pend = 1'b0;
    case (stk_cmd)
      CMD_CLR:  sp = 0;
      CMD_PUSH: if (sp < 8) begin mem[sp] = stk_din; sp++; end else err_pend = 1'b1;
      CMD_POP:  if (sp > 0) begin sp--; pop_val = mem[sp]; end else err_pend = 1'b1;
      default:  ;
    endcase
    if (stk_cmd == CMD_PUSH || stk_cmd == CMD_POP || stk_cmd == CMD_CLR)
      cmd_q.push_back({stk_cmd, (stk_cmd == CMD_PUSH) ? stk_din : 8'h00});
    if (res_valid) rv_cnt++;
    if (err) err_cnt++;
    if (res_valid && err) both_cnt++;
  end

  always @(negedge clk) begin
    stk_dout  <= pop_val;
    stk_empty <= (sp == 0);
    stk_full  <= (sp == 8);
    model_err <= err_pend;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required finish");
    $fatal(1, "watchdog");
  end

  task automatic send_tok(input logic [1:0] k, input logic [2:0] o, input logic [7:0] v);
    int t = 0;
    while (!tok_if.tok_ready && t < 40) begin @(posedge clk); #1; t++; end
    if (!tok_if.tok_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_ready: tok_ready=%b after %0d cycles, required 1", tok_if.tok_ready, t);
    end
    tok_if.tok_kind  = k;
    tok_if.tok_op    = o;
    tok_if.tok_val   = v;
    tok_if.tok_valid = 1'b1;
    @(posedge clk); #1;
    tok_if.tok_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (dbg_state !== ST_IDLE && t < 40) begin @(posedge clk); #1; t++; end
    if (dbg_state !== ST_IDLE) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: state=%0d, required %0d", dbg_state, ST_IDLE);
    end
  endtask

  // Sends an operator and returns the cycle index (accept cycle = 0) in which
  // res_valid is first seen.
  task automatic run_op(input logic [2:0] op, output int lat);
    lat = 1;
    send_tok(KIND_OPER, op, 8'h00);
    while (!res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (stk_cmd !== CMD_CLR) begin n_bad++; $display("FAIL rst_cmd: got %0d, required %0d", stk_cmd, CMD_CLR); end
    n_cmp++; if (stk_din !== 8'h00) begin n_bad++; $display("FAIL rst_din: got %0h, required 0", stk_din); end
    n_cmp++; if (depth !== 4'd0) begin n_bad++; $display("FAIL rst_depth: got %0d, required 0", depth); end
    n_cmp++; if (result !== 8'h00) begin n_bad++; $display("FAIL rst_result: got %0h, required 0", result); end
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_res_valid: got %b, required 0", res_valid); end
    n_cmp++; if (err !== 1'b0 || err_code !== 2'b00) begin n_bad++; $display("FAIL rst_err: got %b/%b, required 0/00", err, err_code); end
    n_cmp++; if (stk_fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %b, required 0", stk_fault); end
    n_cmp++; if (tok_if.tok_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b, required 0", tok_if.tok_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (tok_if.tok_ready !== 1'b1) begin n_bad++; $display("FAIL init_ready: got %b, required 1", tok_if.tok_ready); end
    n_cmp++; if (stk_cmd !== CMD_NOP) begin n_bad++; $display("FAIL idle_cmd: got %0d, required %0d", stk_cmd, CMD_NOP); end
  endtask

  task automatic test_add();
    int lat;
    cmd_q.delete();
    send_tok(KIND_OPND, 3'd0, 8'd3);
    send_tok(KIND_OPND, 3'd0, 8'd4);
    run_op(OP_ADD, lat);
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL add_latency: got %0d, required 8", lat); end
    n_cmp++; if (result !== 8'd7) begin n_bad++; $display("FAIL add_result: got %0h, required 07", result); end
    n_cmp++; if (depth !== 4'd1) begin n_bad++; $display("FAIL add_depth: got %0d, required 1", depth); end
    exp_q = {};
    exp_q.push_back({CMD_PUSH, 8'd3});
    exp_q.push_back({CMD_PUSH, 8'd4});
    exp_q.push_back({CMD_POP, 8'd0});
    exp_q.push_back({CMD_POP, 8'd0});
    exp_q.push_back({CMD_PUSH, 8'd7});
    n_cmp++;
    if (cmd_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL add_cmd_count: got %0d, required %0d", cmd_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (cmd_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL add_cmd[%0d]: got %h, required %h", i, cmd_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_sub();
    int lat;
    send_tok(KIND_OPND, 3'd0, 8'd10);
    send_tok(KIND_OPND, 3'd0, 8'd3);
    run_op(OP_SUB, lat);
    n_cmp++; if (result !== 8'd7) begin n_bad++; $display("FAIL sub_10_3: got %0h, required 07", result); end
    send_tok(KIND_OPND, 3'd0, 8'd3);
    send_tok(KIND_OPND, 3'd0, 8'd10);
    run_op(OP_SUB, lat);
    n_cmp++; if (result !== 8'hF9) begin n_bad++; $display("FAIL sub_3_10: got %0h, required f9", result); end
    n_cmp++; if (depth !== 4'd3) begin n_bad++; $display("FAIL sub_depth: got %0d, required 3", depth); end
  endtask

  task automatic test_mul();
    int lat;
    cmd_q.delete();
    send_tok(KIND_OPND, 3'd0, 8'h20);
    send_tok(KIND_OPND, 3'd0, 8'h10);
    run_op(OP_MUL, lat);
    n_cmp++; if (res_valid !== 1'b1 || result !== 8'h00) begin n_bad++; $display("FAIL mul_result: got rv=%b %0h, required rv=1 00", res_valid, result); end
    @(posedge clk); #1;
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL mul_rv_width: got %b, required 0", res_valid); end
    n_cmp++; if (cmd_q.size() != 5 || cmd_q[cmd_q.size()-1] !== {CMD_PUSH, 8'h00}) begin
      n_bad++; $display("FAIL mul_push: got %0d entries, last %h, required 5, %h", cmd_q.size(), cmd_q[cmd_q.size()-1], {CMD_PUSH, 8'h00});
    end
  endtask

  task automatic test_logic();
    int lat;
    send_tok(KIND_CLEAR, 3'd0, 8'h00);
    send_tok(KIND_OPND, 3'd0, 8'hF0);
    send_tok(KIND_OPND, 3'd0, 8'h3C);
    run_op(OP_AND, lat);
    n_cmp++; if (result !== 8'h30) begin n_bad++; $display("FAIL and: got %0h, required 30", result); end
    send_tok(KIND_OPND, 3'd0, 8'h0F);
    run_op(OP_OR, lat);
    n_cmp++; if (result !== 8'h3F) begin n_bad++; $display("FAIL or: got %0h, required 3f", result); end
    send_tok(KIND_OPND, 3'd0, 8'hFF);
    run_op(OP_XOR, lat);
    n_cmp++; if (result !== 8'hC0) begin n_bad++; $display("FAIL xor: got %0h, required c0", result); end
    n_cmp++; if (depth !== 4'd1) begin n_bad++; $display("FAIL logic_depth: got %0d, required 1", depth); end
  endtask

  task automatic test_overflow();
    send_tok(KIND_CLEAR, 3'd0, 8'h00);
    wait_idle();
    cmd_q.delete();
    for (int i = 1; i <= 8; i++) send_tok(KIND_OPND, 3'd0, 8'(i));
    send_tok(KIND_OPND, 3'd0, 8'hAA);
    n_cmp++; if (err !== 1'b1 || err_code !== ERR_OVF) begin n_bad++; $display("FAIL ovf_err: got %b/%b, required 1/01", err, err_code); end
    n_cmp++; if (depth !== 4'd8) begin n_bad++; $display("FAIL ovf_depth: got %0d, required 8", depth); end
    @(posedge clk); #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ovf_err_width: got %b, required 0", err); end
    n_cmp++;
    if (cmd_q.size() != 8) begin
      n_bad++; $display("FAIL ovf_cmd_count: got %0d, required 8", cmd_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (cmd_q[i] !== {CMD_PUSH, 8'(i + 1)}) begin n_bad++; $display("FAIL ovf_cmd[%0d]: got %h, required %h", i, cmd_q[i], {CMD_PUSH, 8'(i + 1)}); end
      end
    end
    send_tok(KIND_CLEAR, 3'd0, 8'h00);
    n_cmp++; if (depth !== 4'd0) begin n_bad++; $display("FAIL clr_depth: got %0d, required 0", depth); end
    wait_idle();
    @(posedge clk); #1;
    n_cmp++; if (stk_empty !== 1'b1) begin n_bad++; $display("FAIL clr_empty: got %b, required 1", stk_empty); end
  endtask

  task automatic test_underflow();
    int e0;
    cmd_q.delete();
    e0 = err_cnt;
    send_tok(KIND_OPER, OP_ADD, 8'h00);
    n_cmp++; if (err !== 1'b1 || err_code !== ERR_UNF) begin n_bad++; $display("FAIL unf_err: got %b/%b, required 1/10", err, err_code); end
    send_tok(KIND_OPER, 3'b110, 8'h00);
    n_cmp++; if (err !== 1'b1 || err_code !== ERR_ILL) begin n_bad++; $display("FAIL ill_op: got %b/%b, required 1/11", err, err_code); end
    send_tok(KIND_OPND, 3'd0, 8'h01);
    send_tok(KIND_ILL, 3'd0, 8'h00);
    n_cmp++; if (err !== 1'b1 || err_code !== ERR_ILL) begin n_bad++; $display("FAIL ill_kind: got %b/%b, required 1/11", err, err_code); end
    @(posedge clk); #1;
    n_cmp++; if (err !== 1'b0 || err_code !== ERR_ILL) begin n_bad++; $display("FAIL err_hold: got %b/%b, required 0/11", err, err_code); end
    n_cmp++; if (err_cnt - e0 != 3) begin n_bad++; $display("FAIL err_pulses: got %0d, required 3", err_cnt - e0); end
    n_cmp++; if (cmd_q.size() != 1 || cmd_q[0] !== {CMD_PUSH, 8'h01}) begin n_bad++; $display("FAIL unf_cmds: got %0d entries, required one PUSH 01", cmd_q.size()); end
    n_cmp++; if (depth !== 4'd1) begin n_bad++; $display("FAIL unf_depth: got %0d, required 1", depth); end
  endtask

  task automatic test_fault();
    inj_err = 1'b1;
    @(posedge clk); #1;
    inj_err = 1'b0;
    n_cmp++; if (stk_fault !== 1'b1) begin n_bad++; $display("FAIL fault_set: got %b, required 1", stk_fault); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (stk_fault !== 1'b1) begin n_bad++; $display("FAIL fault_sticky: got %b, required 1", stk_fault); end
    send_tok(KIND_CLEAR, 3'd0, 8'h00);
    n_cmp++; if (stk_fault !== 1'b0) begin n_bad++; $display("FAIL fault_clear: got %b, required 0", stk_fault); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int t = 0;
    int rv0;
    int lat;
    send_tok(KIND_OPND, 3'd0, 8'd5);
    send_tok(KIND_OPND, 3'd0, 8'd6);
    send_tok(KIND_OPER, OP_ADD, 8'h00);
    while (dbg_state !== ST_WT_A && t < 20) begin @(posedge clk); #1; t++; end
    n_cmp++; if (dbg_state !== ST_WT_A) begin n_bad++; $display("FAIL mid_reach_wt_a: got %0d, required %0d", dbg_state, ST_WT_A); end
    rv0 = rv_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (stk_cmd !== CMD_CLR) begin n_bad++; $display("FAIL mid_cmd: got %0d, required %0d", stk_cmd, CMD_CLR); end
    n_cmp++; if (depth !== 4'd0) begin n_bad++; $display("FAIL mid_depth: got %0d, required 0", depth); end
    n_cmp++; if (tok_if.tok_ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready_low: got %b, required 0", tok_if.tok_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (tok_if.tok_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_high: got %b, required 1", tok_if.tok_ready); end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (rv_cnt != rv0) begin n_bad++; $display("FAIL mid_no_result: got %0d pulses, required 0", rv_cnt - rv0); end
    send_tok(KIND_OPND, 3'd0, 8'd1);
    send_tok(KIND_OPND, 3'd0, 8'd2);
    run_op(OP_ADD, lat);
    n_cmp++; if (result !== 8'd3 || depth !== 4'd1) begin n_bad++; $display("FAIL mid_recover: got %0h depth %0d, required 03 depth 1", result, depth); end
  endtask

  initial begin
    tok_if.tok_valid = 1'b0;
    tok_if.tok_kind  = 2'b00;
    tok_if.tok_op    = 3'b000;
    tok_if.tok_val   = 8'h00;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_logic();
    test_overflow();
    test_underflow();
    test_fault();
    test_reset_mid();
    n_cmp++; if (both_cnt != 0) begin n_bad++; $display("FAIL err_with_res_valid: got %0d cycles, required 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
